// File: rtl/present_core.sv
// present_core: PRESENT-80/128 block cipher, per-block encrypt or decrypt.
// Define PRESENT_CORE_ZEROIZE_EN to add a zeroize input that wipes keys and state.
module present_core #(
  parameter int KEY_W     = 80,
  parameter int NR_ROUNDS = 31
) (
  input  logic             clk,
  input  logic             n_reset,
`ifdef PRESENT_CORE_ZEROIZE_EN
  input  logic             zeroize,
`endif
  input  logic             key_load,
  input  logic [KEY_W-1:0] key_in,
  output logic             key_ready,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             busy
);

  if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
    $error("present_core: KEY_W must be 80 or 128");
  end
  if (NR_ROUNDS < 1 || NR_ROUNDS > 31) begin : g_bad_rounds
    $error("present_core: NR_ROUNDS must be 1..31");
  end

  localparam int RC_LO = (KEY_W == 128) ? 62 : 15;

  typedef enum logic [1:0] {IDLE, KEYEXP, RUN, DONE} fsm_e;

  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [3:0] r;
    case (x)
      4'h0: r = 4'hC;  4'h1: r = 4'h5;  4'h2: r = 4'h6;  4'h3: r = 4'hB;
      4'h4: r = 4'h9;  4'h5: r = 4'h0;  4'h6: r = 4'hA;  4'h7: r = 4'hD;
      4'h8: r = 4'h3;  4'h9: r = 4'hE;  4'hA: r = 4'hF;  4'hB: r = 4'h8;
      4'hC: r = 4'h4;  4'hD: r = 4'h7;  4'hE: r = 4'h1;
      default: r = 4'h2;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] sbi(input logic [3:0] x);
    logic [3:0] r;
    case (x)
      4'h0: r = 4'h5;  4'h1: r = 4'hE;  4'h2: r = 4'hF;  4'h3: r = 4'h8;
      4'h4: r = 4'hC;  4'h5: r = 4'h1;  4'h6: r = 4'h2;  4'h7: r = 4'hD;
      4'h8: r = 4'hB;  4'h9: r = 4'h4;  4'hA: r = 4'h6;  4'hB: r = 4'h3;
      4'hC: r = 4'h0;  4'hD: r = 4'h7;  4'hE: r = 4'h9;
      default: r = 4'hA;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sb(x[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] s_inv(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sbi(x[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) r[(16*i) % 63] = x[i];
    r[63] = x[63];
    return r;
  endfunction

  function automatic logic [63:0] p_inv(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) r[i] = x[(16*i) % 63];
    r[63] = x[63];
    return r;
  endfunction

  function automatic logic [KEY_W-1:0] key_fwd(
    input logic [KEY_W-1:0] k,
    input logic [4:0]       rc
  );
    logic [KEY_W-1:0] r;
    r = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
    r[KEY_W-1 -: 4] = sb(r[KEY_W-1 -: 4]);
    if (KEY_W == 128) r[KEY_W-5 -: 4] = sb(r[KEY_W-5 -: 4]);
    r[RC_LO +: 5] = r[RC_LO +: 5] ^ rc;
    return r;
  endfunction

  function automatic logic [KEY_W-1:0] key_inv(
    input logic [KEY_W-1:0] k,
    input logic [4:0]       rc
  );
    logic [KEY_W-1:0] r;
    r = k;
    r[RC_LO +: 5] = r[RC_LO +: 5] ^ rc;
    r[KEY_W-1 -: 4] = sbi(r[KEY_W-1 -: 4]);
    if (KEY_W == 128) r[KEY_W-5 -: 4] = sbi(r[KEY_W-5 -: 4]);
    return {r[60:0], r[KEY_W-1:61]};
  endfunction

  fsm_e             fsm_q, fsm_d;
  logic [KEY_W-1:0] master_q, last_q, wk_q;
  logic [63:0]      state_q, out_q;
  logic [4:0]       rnd_q;
  logic             mode_q, kr_q;
  logic             zero;

`ifdef PRESENT_CORE_ZEROIZE_EN
  assign zero = zeroize;
`else
  assign zero = 1'b0;
`endif

  logic             key_take, accept, last_rnd;
  logic [4:0]       rc_dec;
  logic [63:0]      mix, nxt_st;
  logic [KEY_W-1:0] kf, nxt_k;

  assign key_take = key_load && (fsm_q == IDLE || fsm_q == DONE);
  assign in_ready = kr_q && !key_load && !zero &&
                    (fsm_q == IDLE || (fsm_q == DONE && out_ready));
  assign accept   = in_valid && in_ready;
  assign last_rnd = rnd_q == 5'(NR_ROUNDS);
  // decrypt walks the schedule backwards: rc = NR_ROUNDS+1-rnd
  assign rc_dec   = 5'(NR_ROUNDS + 1) - rnd_q;
  assign kf       = key_fwd(wk_q, rnd_q);

  always_comb begin
    mix = state_q ^ wk_q[KEY_W-1 -: 64];
    if (mode_q) begin
      nxt_st = s_inv(p_inv(mix));
      nxt_k  = key_inv(wk_q, rc_dec);
    end else begin
      nxt_st = p_layer(s_layer(mix));
      nxt_k  = kf;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) fsm_q <= IDLE;
    else          fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    if (key_take) fsm_d = KEYEXP;
               else if (accept) fsm_d = RUN;
      KEYEXP:  if (last_rnd) fsm_d = IDLE;
      RUN:     if (last_rnd) fsm_d = DONE;
      DONE:    if (key_take) fsm_d = KEYEXP;
               else if (accept) fsm_d = RUN;
               else if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
    if (zero) fsm_d = IDLE;
  end

  always_comb begin
    out_valid = fsm_q == DONE;
    busy      = fsm_q == KEYEXP || fsm_q == RUN;
    key_ready = kr_q;
    out_data  = out_q;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      master_q <= '0;
      last_q   <= '0;
      wk_q     <= '0;
      state_q  <= '0;
      out_q    <= '0;
      rnd_q    <= '0;
      mode_q   <= 1'b0;
      kr_q     <= 1'b0;
    end else if (zero) begin
      master_q <= '0;
      last_q   <= '0;
      wk_q     <= '0;
      state_q  <= '0;
      out_q    <= '0;
      rnd_q    <= '0;
      kr_q     <= 1'b0;
    end else begin
      unique case (1'b1)
        key_take: begin
          master_q <= key_in;
          wk_q     <= key_in;
          rnd_q    <= 5'd1;
          kr_q     <= 1'b0;
        end
        accept: begin
          state_q <= in_data;
          mode_q  <= in_mode;
          wk_q    <= in_mode ? last_q : master_q;
          rnd_q   <= 5'd1;
        end
        fsm_q == KEYEXP: begin
          wk_q  <= kf;
          rnd_q <= rnd_q + 5'd1;
          if (last_rnd) begin
            last_q <= kf;
            kr_q   <= 1'b1;
          end
        end
        fsm_q == RUN: begin
          state_q <= nxt_st;
          wk_q    <= nxt_k;
          rnd_q   <= rnd_q + 5'd1;
          if (last_rnd) out_q <= nxt_st ^ nxt_k[KEY_W-1 -: 64];
        end
        default: ;
      endcase
    end
  end

endmodule
